// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the pipelined MIPS core.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HOLD,
    HALTED
  } fetch_state_t;

  localparam word_t WORD_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: I-cache request/response plus the IF/ID-side signals.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t imemload;
  logic  imemREN;
  word_t imemaddr;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  logic  if_valid;
  word_t if_instr;
  word_t if_pc;
  word_t if_npc;

  modport master (
    input  ihit, imemload, stall, redirect, redirect_pc, halt,
    output imemREN, imemaddr, if_valid, if_instr, if_pc, if_npc
  );

  modport slave (
    output ihit, imemload, stall, redirect, redirect_pc, halt,
    input  imemREN, imemaddr, if_valid, if_instr, if_pc, if_npc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-cache request, handles redirects and halt.
// Optional skid buffer for an ihit that lands on a stall: define FETCH_SKID_BUF_EN.
//
// state  | meaning
// FETCH  | normal fetch at pc
// DRAIN  | redirect arrived mid-miss; wait for the stale ihit, then jump to tgt
// HOLD   | instruction captured during stall, replayed from buf
// HALTED | fetch stopped until reset
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input logic          CLK,
  input logic          nRST,
  fetch_unit_if.master fif
);

  fetch_state_t state, state_n;
  word_t        pc, pc_n, tgt, tgt_n;
  word_t        redirect_tgt;
  logic         ren, valid;
  word_t        instr, out_pc;
`ifdef FETCH_SKID_BUF_EN
  word_t        buf_instr, buf_instr_n;
  logic         buf_valid, buf_valid_n;
`endif

  // keep pc word-aligned even if a misaligned target slips through
  assign redirect_tgt = {fif.redirect_pc[31:2], 2'b00};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      tgt       <= '0;
`ifdef FETCH_SKID_BUF_EN
      buf_instr <= '0;
      buf_valid <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      tgt       <= tgt_n;
`ifdef FETCH_SKID_BUF_EN
      buf_instr <= buf_instr_n;
      buf_valid <= buf_valid_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    tgt_n       = tgt;
    ren         = 1'b0;
    valid       = 1'b0;
    instr       = fif.imemload;
    out_pc      = pc;
`ifdef FETCH_SKID_BUF_EN
    buf_instr_n = buf_instr;
    buf_valid_n = buf_valid;
`endif
    case (state)
      FETCH: begin
        ren   = !fif.stall;
        valid = fif.ihit && !fif.redirect;
        if (fif.halt) begin
          state_n = HALTED;
        end else if (fif.redirect) begin
          if (fif.ihit || fif.stall) begin
            pc_n = redirect_tgt;
          end else begin
            tgt_n   = redirect_tgt;
            state_n = DRAIN;
          end
        end else if (fif.ihit && !fif.stall) begin
          pc_n = pc + WORD_BYTES;
`ifdef FETCH_SKID_BUF_EN
        end else if (fif.ihit) begin
          buf_instr_n = fif.imemload;
          buf_valid_n = 1'b1;
          pc_n        = pc + WORD_BYTES;
          state_n     = HOLD;
`endif
        end
      end
      DRAIN: begin
        // the cache must see the stale request through, so ren ignores stall
        ren = 1'b1;
        if (fif.halt) begin
          state_n = HALTED;
        end else if (fif.ihit) begin
          pc_n    = fif.redirect ? redirect_tgt : tgt;
          state_n = FETCH;
        end else if (fif.redirect) begin
          tgt_n = redirect_tgt;
        end
      end
`ifdef FETCH_SKID_BUF_EN
      HOLD: begin
        valid  = buf_valid;
        instr  = buf_instr;
        out_pc = pc - WORD_BYTES;
        if (fif.halt) begin
          buf_valid_n = 1'b0;
          state_n     = HALTED;
        end else if (fif.redirect) begin
          buf_valid_n = 1'b0;
          pc_n        = redirect_tgt;
          state_n     = FETCH;
        end else if (!fif.stall) begin
          buf_valid_n = 1'b0;
          state_n     = FETCH;
        end
      end
`endif
      default: ;
    endcase
  end

  assign fif.imemREN  = nRST && ren;
  assign fif.imemaddr = pc;
  assign fif.if_valid = nRST && valid;
  assign fif.if_instr = nRST ? instr : '0;
  assign fif.if_pc    = out_pc;
  assign fif.if_npc   = out_pc + WORD_BYTES;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan scenarios plus randomized traffic vs. a reference model.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  localparam word_t PC_INIT = 32'h0000_0000;

  logic CLK = 1'b0;
  logic nRST;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_unit_if fif ();
  fetch_unit #(.PC_INIT(PC_INIT)) dut (.CLK(CLK), .nRST(nRST), .fif(fif));

  always #5 CLK = ~CLK;

`ifdef FETCH_SKID_BUF_EN
  localparam bit HAS_BUF = 1'b1;
`else
  localparam bit HAS_BUF = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what fetch is doing (running, halted, waiting out a stale miss, replaying a held word).
  bit    m_halted, m_draining, m_holding;
  word_t m_pc, m_tgt, m_held;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_pc = PC_INIT; m_tgt = '0; m_held = '0;
      m_halted = 0; m_draining = 0; m_holding = 0;
    end else if (m_halted) begin
    end else if (fif.halt) begin
      m_halted = 1; m_draining = 0; m_holding = 0;
    end else if (m_holding) begin
      if (fif.redirect) begin m_pc = fif.redirect_pc; m_holding = 0; end
      else if (!fif.stall) m_holding = 0;
    end else if (m_draining) begin
      if (fif.redirect) m_tgt = fif.redirect_pc;
      if (fif.ihit) begin m_pc = m_tgt; m_draining = 0; end
    end else if (fif.redirect) begin
      // request was outstanding only if the cache was asked (no stall) and has not answered
      if (fif.ihit || fif.stall) m_pc = fif.redirect_pc;
      else begin m_tgt = fif.redirect_pc; m_draining = 1; end
    end else if (fif.ihit && !fif.stall) begin
      m_pc = m_pc + 32'd4;
    end else if (fif.ihit && HAS_BUF) begin
      m_held = fif.imemload; m_pc = m_pc + 32'd4; m_holding = 1;
    end
  end

  always @(negedge CLK) begin
    bit    running, e_ren, e_valid;
    word_t e_pc;
    running = !m_halted && !m_draining && !m_holding;
    e_ren   = nRST && (m_draining || (running && !fif.stall));
    e_valid = nRST && (m_holding || (running && fif.ihit && !fif.redirect));
    e_pc    = m_holding ? m_pc - 32'd4 : m_pc;
    check("m_imemREN", 32'(fif.imemREN), 32'(e_ren));
    check("m_if_valid", 32'(fif.if_valid), 32'(e_valid));
    if (!nRST) begin
      check("m_rst_addr", fif.imemaddr, PC_INIT);
      check("m_rst_instr", fif.if_instr, 32'h0);
      check("m_rst_if_pc", fif.if_pc, PC_INIT);
      check("m_rst_if_npc", fif.if_npc, PC_INIT + 32'd4);
    end else begin
      if (e_ren) check("m_imemaddr", fif.imemaddr, m_pc);
      if (e_valid) begin
        check("m_if_instr", fif.if_instr, m_holding ? m_held : fif.imemload);
        check("m_if_pc", fif.if_pc, e_pc);
        check("m_if_npc", fif.if_npc, e_pc + 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  initial begin
    int    halt_cycles;
    word_t r;
    nRST = 1'b0;
    fif.ihit = 0; fif.imemload = 32'hDEAD_BEEF; fif.stall = 0;
    fif.redirect = 0; fif.redirect_pc = '0; fif.halt = 0;
    tick(); tick();
    check("rst_ren", 32'(fif.imemREN), 32'h0);
    check("rst_valid", 32'(fif.if_valid), 32'h0);
    check("rst_instr", fif.if_instr, 32'h0);
    nRST = 1'b1;

    // sequential hits
    fif.ihit = 1; fif.imemload = 32'h2001_0005; settle();
    check("seq0_valid", 32'(fif.if_valid), 32'h1);
    check("seq0_pc", fif.if_pc, 32'h0);
    check("seq0_instr", fif.if_instr, 32'h2001_0005);
    tick(); fif.imemload = 32'h2002_0007; settle();
    check("seq1_pc", fif.if_pc, 32'h4);
    check("seq1_npc", fif.if_npc, 32'h8);
    tick(); fif.ihit = 0; settle();

    // redirect during miss at pc 8
    check("miss_addr", fif.imemaddr, 32'h8);
    check("miss_ren", 32'(fif.imemREN), 32'h1);
    tick(); tick();
    fif.redirect = 1; fif.redirect_pc = 32'h40; settle();
    check("miss_redir_valid", 32'(fif.if_valid), 32'h0);
    tick(); fif.redirect = 0; fif.stall = 1; settle();
    check("drain_ren_stall", 32'(fif.imemREN), 32'h1);
    check("drain_addr", fif.imemaddr, 32'h8);
    tick(); fif.stall = 0; tick();
    fif.ihit = 1; settle();
    check("drain_hit_valid", 32'(fif.if_valid), 32'h0);
    check("drain_hit_addr", fif.imemaddr, 32'h8);
    tick(); fif.ihit = 0; settle();
    check("after_drain_addr", fif.imemaddr, 32'h40);

    // redirect coincident with hit
    fif.ihit = 1; fif.redirect = 1; fif.redirect_pc = 32'h100; settle();
    check("hit_redir_valid", 32'(fif.if_valid), 32'h0);
    tick(); fif.redirect = 0; fif.stall = 1; fif.imemload = 32'h1234_5678; settle();
    check("redir_addr", fif.imemaddr, 32'h100);
    check("stall_ren0", 32'(fif.imemREN), 32'h0);
    tick(); settle();
    check("stall_ren1", 32'(fif.imemREN), 32'h0);
    tick(); tick(); fif.stall = 0; settle();
    check("unstall_valid", 32'(fif.if_valid), 32'h1);
    check("unstall_pc", fif.if_pc, 32'h100);
    check("unstall_instr", fif.if_instr, 32'h1234_5678);
    tick(); fif.ihit = 0; settle();
    check("post_stall_addr", fif.imemaddr, 32'h104);

    // wrap around the top of the address space
    fif.stall = 1; fif.redirect = 1; fif.redirect_pc = 32'hFFFF_FFFC;
    tick(); fif.stall = 0; fif.redirect = 0; fif.ihit = 1; settle();
    check("wrap_pc", fif.if_pc, 32'hFFFF_FFFC);
    check("wrap_npc", fif.if_npc, 32'h0);
    tick(); fif.ihit = 0; settle();
    check("wrap_addr", fif.imemaddr, 32'h0);

    // halt beats a simultaneous redirect and sticks
    fif.halt = 1; fif.redirect = 1; fif.redirect_pc = 32'h200;
    tick(); fif.halt = 0;
    for (int i = 0; i < 4; i++) begin
      fif.ihit = i[0]; fif.redirect = ~i[0]; settle();
      check("halted_ren", 32'(fif.imemREN), 32'h0);
      check("halted_valid", 32'(fif.if_valid), 32'h0);
      tick();
    end
    fif.ihit = 0; fif.redirect = 0;
    nRST = 0; tick(); nRST = 1;

    // reset pulse in the middle of a drain
    fif.redirect = 1; fif.redirect_pc = 32'h80;
    tick(); fif.redirect = 0; #1;
    nRST = 0; #1;
    check("async_rst_ren", 32'(fif.imemREN), 32'h0);
    check("async_rst_addr", fif.imemaddr, PC_INIT);
    tick(); nRST = 1; settle();
    check("rst_restart_addr", fif.imemaddr, PC_INIT);
    check("rst_restart_ren", 32'(fif.imemREN), 32'h1);
    tick();

    // randomized traffic
    halt_cycles = 0;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom;
      fif.ihit     = ($urandom_range(0, 99) < 55);
      fif.stall    = ($urandom_range(0, 99) < 25);
      fif.redirect = ($urandom_range(0, 99) < 10);
      fif.halt     = ($urandom_range(0, 299) == 0);
      fif.imemload = $urandom;
      fif.redirect_pc = r & 32'hFFFF_FFFC;
      halt_cycles = m_halted ? halt_cycles + 1 : 0;
      if (halt_cycles > 5 || $urandom_range(0, 499) == 0) begin
        nRST = 0; tick(); nRST = 1; halt_cycles = 0;
      end else begin
        tick();
      end
    end

    fif.ihit = 0; fif.stall = 0; fif.redirect = 0; fif.halt = 0;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the IF/ID latch. It owns the program counter and drives the instruction-memory request (imemREN/imemaddr) to the I-cache, handling its ihit handshake. It presents each fetched instruction with its PC and PC+4 to the IF/ID latch. It also handles downstream stalls, branch/jump redirects (including redirects that arrive mid-miss) and halt.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  I-cache: imemload valid for the current imemaddr this cycle.
- imemload  in  32  I-cache read data.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  instruction address. Held stable while imemREN=1 and ihit=0.
- stall  in  1  IF/ID latch not accepting this cycle (inverse of its enable).
- redirect  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  32  target for redirect. Word-aligned.
- halt  in  1  halt instruction reached. Fetch stops permanently until reset.
- if_valid  out  1  if_instr/if_pc/if_npc are a live instruction.
- if_instr  out  32  fetched instruction (to IF/ID imemload).
- if_pc  out  32  address of if_instr (to IF/ID imemaddr).
- if_npc  out  32  if_pc + 4.

## Operation
- Registers: pc (32), state, pending target tgt (32). With the buffer option, also buf_instr and buf_valid.
- States: FETCH, DRAIN, HOLD (buffer option only), HALTED.
- FETCH:
  - imemREN = !stall. imemaddr = pc.
  - if_valid = ihit && !redirect.
  - On ihit && !stall && !redirect: pc <= pc+4.
- Stall in FETCH:
  - ihit && stall, no buffer: the instruction is dropped, pc unchanged, and the word is refetched.
  - ihit && stall, with buffer: capture into buf, pc <= pc+4, go to HOLD.
- Redirect in FETCH:
  - If ihit or imemREN=0: pc <= redirect_pc and stay in FETCH. The current instruction is squashed (if_valid=0).
  - If a miss is outstanding (imemREN=1, ihit=0): tgt <= redirect_pc and go to DRAIN.
- DRAIN:
  - imemREN=1 regardless of stall. imemaddr = pc (old address held stable). if_valid=0.
  - On ihit: the data is discarded, pc <= tgt, go to FETCH.
  - A further redirect in DRAIN overwrites tgt.
- HOLD:
  - imemREN=0. if_valid=1. Outputs come from buf, with if_pc = pc-4.
  - On !stall: the instruction is consumed and the unit returns to FETCH.
  - On redirect: buf is discarded, pc <= redirect_pc, go to FETCH.
- HALTED: imemREN=0, if_valid=0. Only reset leaves this state.
- Priority, highest first: nRST, halt, redirect, stall, ihit.
  - halt && redirect in the same cycle: go to HALTED.
  - halt during a miss: go to HALTED immediately; the late ihit is ignored.
- Arithmetic: pc+4 is a 32-bit add and wraps from 32'hFFFF_FFFC to 0. Bits [1:0] of pc are always 0.

## Timing
- Reset (nRST low, asynchronous): pc=PC_INIT, state=FETCH, buf_valid=0, tgt=0. While nRST is low, outputs are gated to imemREN=0 and if_valid=0. imemaddr=PC_INIT, if_instr=0, if_pc=PC_INIT, if_npc=PC_INIT+4.
- Output timing:
  - imemaddr, imemREN and the state-dependent outputs come from registers plus combinational decode.
  - if_instr follows imemload with zero latency in FETCH.
- Throughput: one instruction per ihit cycle. Back-to-back ihit with no stall gives sequential PCs on consecutive cycles.
- Redirect latency:
  - No outstanding miss: the fetch from redirect_pc starts the cycle after redirect.
  - Outstanding miss: the fetch starts the cycle after the draining ihit.
- Reset mid-DRAIN/HOLD: all state is lost, and fetch restarts from PC_INIT after nRST rises.

## Configuration
- FETCH_SKID_BUF_EN:
  - Defined: the HOLD state and the 1-entry buffer exist. An ihit that coincides with a stall is kept, not refetched.
  - Undefined: HOLD, buf_instr and buf_valid are absent. An ihit during stall is dropped and the same pc is refetched after the stall.
- The architectural instruction stream is identical either way; only the cycle count differs.

## Structure
- In cpu_types_pkg:
  - word_t.
  - fetch_state_t enum {FETCH, DRAIN, HOLD, HALTED}.
  - constant WORD_BYTES = 4.
- No sub-module. The single module fetch_unit contains the FSM, PC and buffer.

## Test plan
- Reset with PC_INIT=0, then ihit every cycle with imemload=32'h2001_0005, 32'h2002_0007, ... -> if_pc = 0, 4, 8 on consecutive cycles, if_valid=1, if_npc=if_pc+4.
- ihit=0 for 5 cycles at pc=8, then redirect_pc=32'h40 at cycle 2 -> imemaddr stays 8 until ihit. That instruction has if_valid=0, and the next imemaddr is 32'h40.
- Redirect to 32'h100 coincident with ihit at pc=12 -> if_valid=0 that cycle; the next imemaddr is 32'h100.
- stall=1 for 3 cycles coincident with ihit at pc=16:
  - With FETCH_SKID_BUF_EN: the instruction is held and emitted with if_pc=16 when stall drops; imemREN=0 during the hold.
  - Without FETCH_SKID_BUF_EN: 16 is refetched.
- halt asserted with a simultaneous redirect -> imemREN=0 and if_valid=0 forever; a later ihit/redirect has no effect until nRST.
- Start at pc=32'hFFFF_FFFC with ihit -> the next imemaddr is 0; nRST pulsed mid-DRAIN -> imemaddr=PC_INIT and imemREN=0 asynchronously.
